// File: rtl/asrv32_fetch_pkg.sv
// Shared types and constants for the ASRV32 instruction-fetch stage.
// PC_RESET_DEFAULT is also used by writeback for its trap vectors.
package asrv32_fetch_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // One decision per cycle; the top module turns it into register updates.
    typedef enum logic [2:0] {
        FA_HOLD,
        FA_REDIRECT,
        FA_DRAIN,
        FA_ACCEPT,
        FA_PARK,
        FA_BUBBLE
    } fetch_act_e;

    // Writeback outranks the ALU; alignment faults are raised further down the pipe.
    function automatic logic [31:0] redirect_target(
        input logic        wb_sel,
        input logic [31:0] wb_pc,
        input logic [31:0] alu_pc
    );
        logic [31:0] t;
        t = wb_sel ? wb_pc : alu_pc;
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/asrv32_fetch_skid.sv
// One-entry {inst, pc} holding buffer for a response that arrives while decode is stalled.
module asrv32_fetch_skid
    import asrv32_fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic         clear_i,
    input  fetch_entry_t entry_i,
    output fetch_entry_t entry_o,
    output logic         valid_o
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/asrv32_fetch.sv
// ASRV32 instruction-fetch stage: PC ownership, stb/ack fetch, IF/ID registers and redirect flush.
module asrv32_fetch
    import asrv32_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst_ifid,
    output logic [31:0] o_pc_ifid,
    input  logic        i_alu_change_pc,
    input  logic [31:0] i_alu_next_pc,
    input  logic        i_writeback_change_pc,
    input  logic [31:0] i_writeback_next_pc,
    output logic        o_ce,
    input  logic        i_stall,
    output logic        o_flush
);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_ifid_q, inst_ifid_d;
    logic [31:0]  pc_ifid_q, pc_ifid_d;
    logic         ce_q, ce_d;
    logic         started_q;
    logic         handshake;
    logic         skid_valid;
    fetch_entry_t skid_entry;
    fetch_entry_t park_entry;
    fetch_act_e   act;

    assign o_flush    = i_alu_change_pc | i_writeback_change_pc;
    assign o_stb_inst = started_q & ~skid_valid;
    assign handshake  = o_stb_inst & i_ack_inst;
    assign park_entry = '{inst: i_inst, pc: pc_q};

    // Redirect beats everything, then a parked response, then a live handshake.
    always_comb begin
        act = FA_HOLD;
        if (o_flush) begin
            act = FA_REDIRECT;
        end else if (skid_valid) begin
            act = i_stall ? FA_HOLD : FA_DRAIN;
        end else if (handshake) begin
            act = i_stall ? FA_PARK : FA_ACCEPT;
        end else if (!i_stall) begin
            act = FA_BUBBLE;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        inst_ifid_d = inst_ifid_q;
        pc_ifid_d   = pc_ifid_q;
        ce_d        = ce_q;
        unique case (act)
            FA_REDIRECT: begin
                pc_d = redirect_target(i_writeback_change_pc, i_writeback_next_pc, i_alu_next_pc);
                ce_d = 1'b0;
            end
            FA_DRAIN: begin
                inst_ifid_d = skid_entry.inst;
                pc_ifid_d   = skid_entry.pc;
                ce_d        = 1'b1;
            end
            FA_ACCEPT: begin
                inst_ifid_d = i_inst;
                pc_ifid_d   = pc_q;
                ce_d        = 1'b1;
                pc_d        = pc_q + PC_STEP;
            end
            FA_PARK: begin
                pc_d = pc_q + PC_STEP;
            end
            FA_BUBBLE: begin
                ce_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q        <= PC_RESET;
            inst_ifid_q <= '0;
            pc_ifid_q   <= '0;
            ce_q        <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inst_ifid_q <= inst_ifid_d;
            pc_ifid_q   <= pc_ifid_d;
            ce_q        <= ce_d;
            started_q   <= 1'b1;
        end
    end

    asrv32_fetch_skid u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load_i  (act == FA_PARK),
        .drain_i (act == FA_DRAIN),
        .clear_i (act == FA_REDIRECT),
        .entry_i (park_entry),
        .entry_o (skid_entry),
        .valid_o (skid_valid)
    );

    assign o_iaddr     = pc_q;
    assign o_inst_ifid = inst_ifid_q;
    assign o_pc_ifid   = pc_ifid_q;
    assign o_ce        = ce_q;

endmodule

// File: tb/tb_asrv32_fetch.sv
// Bench for asrv32_fetch: directed stimulus, expected IF/ID PCs queued at handshake time.
module tb_asrv32_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] o_iaddr;
    logic        o_stb_inst;
    logic        i_ack_inst;
    logic [31:0] i_inst;
    logic [31:0] o_inst_ifid;
    logic [31:0] o_pc_ifid;
    logic        i_alu_change_pc;
    logic [31:0] i_alu_next_pc;
    logic        i_writeback_change_pc;
    logic [31:0] i_writeback_next_pc;
    logic        o_ce;
    logic        i_stall;
    logic        o_flush;

    asrv32_fetch #(.PC_RESET(RST_PC)) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .o_iaddr               (o_iaddr),
        .o_stb_inst            (o_stb_inst),
        .i_ack_inst            (i_ack_inst),
        .i_inst                (i_inst),
        .o_inst_ifid           (o_inst_ifid),
        .o_pc_ifid             (o_pc_ifid),
        .i_alu_change_pc       (i_alu_change_pc),
        .i_alu_next_pc         (i_alu_next_pc),
        .i_writeback_change_pc (i_writeback_change_pc),
        .i_writeback_next_pc   (i_writeback_next_pc),
        .o_ce                  (o_ce),
        .i_stall               (i_stall),
        .o_flush               (o_flush)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory is combinational: data is valid in the ack cycle.
    assign i_inst = mem_word(o_iaddr);

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_push   = 0;
    int          n_pop    = 0;
    logic [31:0] sb_q[$];
    logic        last_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        sb_q.push_back(pc);
        n_push++;
    endtask

    // A fresh IF/ID word is present when o_ce is high after an unstalled edge.
    task automatic monitor();
        logic [31:0] pc;
        if (i_rst_n && o_ce && !last_stall) begin
            check("sb_avail", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                pc = sb_q.pop_front();
                n_pop++;
                check("sb_pc", o_pc_ifid, pc);
                check("sb_inst", o_inst_ifid, mem_word(pc));
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        last_stall = i_stall;
        @(negedge i_clk);
        monitor();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_ack_inst = 1'b0;
        i_stall = 1'b0;
        i_alu_change_pc = 1'b0;
        i_alu_next_pc = '0;
        i_writeback_change_pc = 1'b0;
        i_writeback_next_pc = '0;
        repeat (2) @(negedge i_clk);

        check("rst_iaddr", o_iaddr, RST_PC);
        check("rst_stb", o_stb_inst, 0);
        check("rst_ce", o_ce, 0);
        check("rst_pc_ifid", o_pc_ifid, 0);
        check("rst_inst_ifid", o_inst_ifid, 0);

        i_rst_n = 1'b1;
        i_ack_inst = 1'b1;
        check("pre_stb", o_stb_inst, 0);
        tick();

        // zero-wait stream
        check("zw_iaddr0", o_iaddr, 32'h0);
        check("zw_stb", o_stb_inst, 1);
        expect_fetch(32'h0);
        tick();
        check("zw_iaddr4", o_iaddr, 32'h4);
        check("zw_ce", o_ce, 1);
        expect_fetch(32'h4);
        tick();

        // two wait cycles at 0x8
        check("wait_iaddr_a", o_iaddr, 32'h8);
        i_ack_inst = 1'b0;
        tick();
        check("wait_iaddr_b", o_iaddr, 32'h8);
        check("wait_ce_b", o_ce, 0);
        tick();
        check("wait_iaddr_c", o_iaddr, 32'h8);
        check("wait_ce_c", o_ce, 0);
        i_ack_inst = 1'b1;
        expect_fetch(32'h8);
        tick();

        // stall during handshake at 0xC
        check("stall_iaddr", o_iaddr, 32'hC);
        i_stall = 1'b1;
        expect_fetch(32'hC);
        tick();
        check("stall_stb_drop", o_stb_inst, 0);
        check("stall_iaddr_next", o_iaddr, 32'h10);
        check("stall_ce_hold", o_ce, 1);
        check("stall_pc_hold", o_pc_ifid, 32'h8);
        tick();
        tick();
        i_stall = 1'b0;
        check("drain_stb", o_stb_inst, 0);
        tick();
        check("drain_pc", o_pc_ifid, 32'hC);
        check("drain_ce", o_ce, 1);
        check("drain_stb_back", o_stb_inst, 1);

        for (int a = 'h10; a <= 'h1C; a += 4) begin
            check("run_iaddr", o_iaddr, 32'(a));
            expect_fetch(32'(a));
            tick();
        end

        // ALU redirect while acking 0x20
        check("br_iaddr", o_iaddr, 32'h20);
        i_alu_change_pc = 1'b1;
        i_alu_next_pc = 32'h100;
        #1 check("br_flush", o_flush, 1);
        tick();
        i_alu_change_pc = 1'b0;
        #1 check("br_flush_off", o_flush, 0);
        check("br_iaddr_tgt", o_iaddr, 32'h100);
        check("br_ce", o_ce, 0);
        expect_fetch(32'h100);
        tick();

        // both redirects with a full buffer under stall
        check("dual_iaddr", o_iaddr, 32'h104);
        i_stall = 1'b1;
        tick();
        check("dual_full", o_stb_inst, 0);
        i_alu_change_pc = 1'b1;
        i_alu_next_pc = 32'h200;
        i_writeback_change_pc = 1'b1;
        i_writeback_next_pc = 32'h83;
        #1 check("dual_flush", o_flush, 1);
        tick();
        i_alu_change_pc = 1'b0;
        i_writeback_change_pc = 1'b0;
        i_stall = 1'b0;
        check("dual_iaddr_tgt", o_iaddr, 32'h80);
        check("dual_empty", o_stb_inst, 1);
        check("dual_ce", o_ce, 0);
        expect_fetch(32'h80);
        tick();

        // PC wrap
        check("wrap_pre", o_iaddr, 32'h84);
        i_alu_change_pc = 1'b1;
        i_alu_next_pc = 32'hFFFF_FFFC;
        tick();
        i_alu_change_pc = 1'b0;
        check("wrap_iaddr", o_iaddr, 32'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC);
        tick();
        check("wrap_zero", o_iaddr, 32'h0);
        expect_fetch(32'h0);
        tick();

        // async reset while a request is outstanding
        check("ar_iaddr", o_iaddr, 32'h4);
        check("ar_ce_pre", o_ce, 1);
        i_ack_inst = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check("ar_iaddr_rst", o_iaddr, RST_PC);
        check("ar_ce", o_ce, 0);
        check("ar_stb", o_stb_inst, 0);
        check("ar_pc_ifid", o_pc_ifid, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ack_inst = 1'b1;
        tick();
        check("ar_restart", o_iaddr, RST_PC);
        expect_fetch(RST_PC);
        tick();
        check("ar_next", o_iaddr, RST_PC + 32'd4);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("sb_count", 32'(n_pop), 32'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
